// File: rtl/alu_share_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter_pkg
// Purpose  : Shared definitions for the ALU sharing arbiter: ALU opcode
//            encodings, requester IDs and the issue/response stage records.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package alu_share_arbiter_pkg;

    // ALU opcode encodings carried on aluOp (passed through untouched)
    localparam logic [2:0] c_ALUOP_ADD  = 3'b000;
    localparam logic [2:0] c_ALUOP_SUB  = 3'b001;
    localparam logic [2:0] c_ALUOP_FUNC = 3'b010;

    // Requester identities, also the value reported on rsp_id
    typedef enum logic {
        ID_EXEC   = 1'b0,
        ID_BRANCH = 1'b1
    } req_id_e;

    // Issue-stage control record; operands are held alongside it because
    // their width is a module parameter
    typedef struct packed {
        logic       valid;
        req_id_e    id;
        logic [3:0] func;
        logic [2:0] aluop;
    } is_ctrl_t;

    // Response-stage control record; result is held alongside it
    typedef struct packed {
        logic    valid;
        req_id_e id;
        logic    branch;
    } rs_ctrl_t;

endpackage : alu_share_arbiter_pkg
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant. The preference pointer moves to the
//            losing side whenever the parent signals an accepted grant.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_req[1:0]    - request vector (bit N = requester N)
//            i_accept      - the current grant was consumed this cycle
//            o_grant[1:0]  - one-hot (or zero) grant, combinational
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    // 0 = requester 0 preferred on a tie
    logic r_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (i_req[0] && i_req[1]) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end else begin
            o_grant = i_req;
        end
    end

    // After a win, the other side gets preference next time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_accept) begin
            r_ptr <= ~o_grant[1];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Shares one combinational ALU between the integer-execute path
//            (requester 0) and the branch/address path (requester 1).
//            Round-robin arbitration, a registered issue stage driving the
//            ALU and a tagged response register, full backpressure.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            reqN_valid/ready         - request handshakes (N = 0, 1)
//            reqN_dataA/dataB         - operands
//            reqN_func, reqN_aluOp    - ALU function / opcode
//            alu_dataA/dataB/func/aluOp - issue stage to the ALU
//            alu_result, alu_branch   - combinational ALU outputs
//            rsp_valid/ready          - response handshake
//            rsp_id, rsp_result, rsp_branch - response payload
//            perf_grant0/1            - grant counters (ALU_ARB_PERF_EN only)
// Config   : define ALU_ARB_PERF_EN to add the grant counters
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dataA,
    input  logic [WIDTH-1:0] req0_dataB,
    input  logic [3:0]       req0_func,
    input  logic [2:0]       req0_aluOp,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dataA,
    input  logic [WIDTH-1:0] req1_dataB,
    input  logic [3:0]       req1_func,
    input  logic [2:0]       req1_aluOp,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    output logic [3:0]       alu_func,
    output logic [2:0]       alu_aluOp,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_branch,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_branch
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]      perf_grant0,
    output logic [31:0]      perf_grant1
`endif
);

    is_ctrl_t         r_is;
    logic [WIDTH-1:0] r_is_data_a;
    logic [WIDTH-1:0] r_is_data_b;
    rs_ctrl_t         r_rs;
    logic [WIDTH-1:0] r_rs_result;

    logic [1:0] w_grant;
    logic       w_is_adv;
    logic       w_can_accept;
    logic       w_accept;

    // Readies depend only on request valids, pointer, stage valids and
    // rsp_ready; nothing from the ALU result feeds back into them.
    assign w_is_adv     = r_is.valid && (!r_rs.valid || rsp_ready);
    assign w_can_accept = !r_is.valid || w_is_adv;
    // Held low during reset so nothing is accepted in the reset cycle
    assign req0_ready   = !rst && w_grant[0] && w_can_accept;
    assign req1_ready   = !rst && w_grant[1] && w_can_accept;
    assign w_accept     = req0_ready || req1_ready;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .i_req    ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // Issue stage: operand fields only change on an accept, so the ALU
    // inputs hold their last value while the stage is empty or stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is        <= '0;
            r_is_data_a <= '0;
            r_is_data_b <= '0;
        end else if (w_accept) begin
            r_is.valid <= 1'b1;
            if (w_grant[1]) begin
                r_is.id     <= ID_BRANCH;
                r_is.func   <= req1_func;
                r_is.aluop  <= req1_aluOp;
                r_is_data_a <= req1_dataA;
                r_is_data_b <= req1_dataB;
            end else begin
                r_is.id     <= ID_EXEC;
                r_is.func   <= req0_func;
                r_is.aluop  <= req0_aluOp;
                r_is_data_a <= req0_dataA;
                r_is_data_b <= req0_dataB;
            end
        end else if (w_is_adv) begin
            r_is.valid <= 1'b0;
        end
    end

    // Response stage: a refill takes precedence over a drain so that a
    // simultaneous drain and refill leaves the stage full with new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs        <= '0;
            r_rs_result <= '0;
        end else if (w_is_adv) begin
            r_rs.valid  <= 1'b1;
            r_rs.id     <= r_is.id;
            r_rs.branch <= alu_branch;
            r_rs_result <= alu_result;
        end else if (rsp_ready) begin
            r_rs.valid <= 1'b0;
        end
    end

    assign alu_dataA  = r_is_data_a;
    assign alu_dataB  = r_is_data_b;
    assign alu_func   = r_is.func;
    assign alu_aluOp  = r_is.aluop;

    assign rsp_valid  = r_rs.valid;
    assign rsp_id     = r_rs.id;
    assign rsp_result = r_rs_result;
    assign rsp_branch = r_rs.branch;

`ifdef ALU_ARB_PERF_EN
    logic [31:0] r_perf_grant0;
    logic [31:0] r_perf_grant1;

    // Free-running 32-bit counters; natural wrap at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_grant0 <= '0;
            r_perf_grant1 <= '0;
        end else begin
            if (req0_valid && req0_ready) begin
                r_perf_grant0 <= r_perf_grant0 + 32'd1;
            end
            if (req1_valid && req1_ready) begin
                r_perf_grant1 <= r_perf_grant1 + 32'd1;
            end
        end
    end

    assign perf_grant0 = r_perf_grant0;
    assign perf_grant1 = r_perf_grant1;
`endif

endmodule : alu_share_arbiter
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Self-checking bench for alu_share_arbiter. A behavioural ALU is
//            attached to the ALU port; accepted requests push their expected
//            response into a queue and a response monitor pops and compares.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_dataA, req0_dataB, req1_dataA, req1_dataB;
    logic [3:0]   req0_func, req1_func;
    logic [2:0]   req0_aluOp, req1_aluOp;
    logic [W-1:0] alu_dataA, alu_dataB, alu_result;
    logic [3:0]   alu_func;
    logic [2:0]   alu_aluOp;
    logic         alu_branch;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_branch;
    logic [W-1:0] rsp_result;
`ifdef ALU_ARB_PERF_EN
    logic [31:0]  perf_grant0, perf_grant1;
`endif

    alu_share_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_dataA (req0_dataA),
        .req0_dataB (req0_dataB),
        .req0_func  (req0_func),
        .req0_aluOp (req0_aluOp),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_dataA (req1_dataA),
        .req1_dataB (req1_dataB),
        .req1_func  (req1_func),
        .req1_aluOp (req1_aluOp),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .alu_func   (alu_func),
        .alu_aluOp  (alu_aluOp),
        .alu_result (alu_result),
        .alu_branch (alu_branch),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_branch (rsp_branch)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grant0 (perf_grant0),
        .perf_grant1 (perf_grant1)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: {branch, result}
    function automatic logic [W:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] f, input logic [2:0] op);
        logic [W-1:0] r;
        logic         br;
        r  = '0;
        br = 1'b0;
        case (op)
            c_ALUOP_ADD: r = a + b;
            c_ALUOP_SUB: r = a - b;
            c_ALUOP_FUNC: begin
                case (f[2:0])
                    3'd0:    r = f[3] ? a - b : a + b;
                    3'd1:    r = a << b[4:0];
                    3'd4:    r = a ^ b;
                    3'd6:    r = a | b;
                    3'd7:    r = a & b;
                    default: r = a + b;
                endcase
                case (f[2:0])
                    3'd0:    br = (a == b);
                    3'd1:    br = (a != b);
                    3'd4:    br = ($signed(a) < $signed(b));
                    default: br = 1'b0;
                endcase
            end
            default: r = '0;
        endcase
        return {br, r};
    endfunction

    always_comb {alu_branch, alu_result} = alu_ref(alu_dataA, alu_dataB, alu_func, alu_aluOp);

    // ---------------------------------------------------------------- checks
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        failures++;
        $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ------------------------------------------------------------ scoreboard
    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         br;
    } exp_t;

    exp_t         q[$];
    int           acc_total = 0;
    int           last_acc_cyc = 0;
    int           rsp_count = 0;
    int           last_rsp_cyc = 0;
    logic [W-1:0] last_rsp_result = '0;
    logic         last_rsp_id = 1'b0;
    logic         last_rsp_branch = 1'b0;

    // Accept monitor: round-robin model plus expected-response push
    initial begin
        logic pref;
        logic a0, a1, want;
        exp_t e;
        pref = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pref = 1'b0;
            end else begin
                a0 = req0_valid && req0_ready;
                a1 = req1_valid && req1_ready;
                if (req0_ready) check_eq("ready0_without_valid", req0_valid, 1);
                if (req1_ready) check_eq("ready1_without_valid", req1_valid, 1);
                if (req0_ready || req1_ready)
                    check_eq("ready_onehot", $countones({req0_ready, req1_ready}), 1);
                if (a0 || a1) begin
                    want = (req0_valid && req1_valid) ? pref : req1_valid;
                    check_eq("grant_winner", a1, want);
                    pref = ~a1;
                    e.id = a1;
                    if (a1) {e.br, e.res} = alu_ref(req1_dataA, req1_dataB, req1_func, req1_aluOp);
                    else    {e.br, e.res} = alu_ref(req0_dataA, req0_dataB, req0_func, req0_aluOp);
                    q.push_back(e);
                    acc_total++;
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    // Response monitor: the response register must always show the oldest
    // outstanding expected response, and may not drop it until taken.
    initial begin
        logic hold;
        exp_t e;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                hold = 1'b0;
            end else begin
                if (hold) check_eq("rsp_held_valid", rsp_valid, 1);
                if (rsp_valid) begin
                    if (q.size() == 0) begin
                        fail_now("rsp_unexpected", rsp_result, 0);
                    end else begin
                        e = q[0];
                        check_eq("rsp_id", rsp_id, e.id);
                        check_eq("rsp_result", rsp_result, e.res);
                        check_eq("rsp_branch", rsp_branch, e.br);
                        if (rsp_ready) begin
                            void'(q.pop_front());
                            rsp_count++;
                            last_rsp_cyc    = cyc;
                            last_rsp_result = rsp_result;
                            last_rsp_id     = rsp_id;
                            last_rsp_branch = rsp_branch;
                        end
                    end
                end
                hold = rsp_valid && !rsp_ready;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    bit rr_rand = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge
    task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] f, input logic [2:0] op);
        int n;
        if (id) begin
            req1_dataA = a; req1_dataB = b; req1_func = f; req1_aluOp = op; req1_valid = 1'b1;
        end else begin
            req0_dataA = a; req0_dataB = b; req0_func = f; req0_aluOp = op; req0_valid = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) break;
            n++;
            if (n > 300) begin
                fail_now(id ? "req1_accept_timeout" : "req0_accept_timeout", n, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic issue_rand(input bit id);
        logic [W-1:0] a, b;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        issue(id, a, b, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns at posedge+1 once every expected response has been taken
    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) fail_now("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s, a_before, r_before;
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_dataA = '0; req0_dataB = '0; req0_func = '0; req0_aluOp = '0;
        req1_dataA = '0; req1_dataB = '0; req1_func = '0; req1_aluOp = '0;
        repeat (3) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        @(negedge clk);
        check_eq("reset_req0_ready", req0_ready, 0);
        check_eq("reset_rsp_valid", rsp_valid, 0);
        check_eq("reset_alu_data", {alu_dataA, alu_dataB}, 0);
        check_eq("reset_alu_ctl", {alu_func, alu_aluOp}, 0);
        check_eq("reset_rsp_fields", {rsp_id, rsp_branch, rsp_result}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        rsp_ready = 1'b1;

        // Single add from requester 0
        issue(0, 32'd5, 32'd7, 4'h0, c_ALUOP_ADD);
        wait_drain();
        check_eq("t1_latency", last_rsp_cyc - last_acc_cyc, 2);
        check_eq("t1_result", last_rsp_result, 32'd12);
        check_eq("t1_id", last_rsp_id, 0);

        // Both requesters continuously valid: alternation, one per cycle
        s = cyc;
        a_before = acc_total;
        fork
            repeat (6) issue_rand(0);
            repeat (6) issue_rand(1);
        join
        wait_drain();
        check_eq("t2_accepts", acc_total - a_before, 12);
        check_eq("t2_throughput", last_acc_cyc - s, 11);

        // Func-decoded op from requester 1
        issue(1, 32'h10, 32'h10, 4'h0, c_ALUOP_FUNC);
        wait_drain();
        check_eq("t3_result", last_rsp_result, 32'h20);
        check_eq("t3_branch", last_rsp_branch, 1);
        check_eq("t3_id", last_rsp_id, 1);

        // Backpressure: only two ops fit while the response is not taken
        rsp_ready = 1'b0;
        a_before = acc_total;
        r_before = rsp_count;
        fork
            begin
                issue(0, 32'd1, 32'd2, 4'h0, c_ALUOP_ADD);
                issue(0, 32'd10, 32'd20, 4'h0, c_ALUOP_ADD);
                issue(0, 32'd100, 32'd1, 4'h0, c_ALUOP_SUB);
            end
            begin
                repeat (6) @(negedge clk);
                check_eq("t4_accepts_stalled", acc_total - a_before, 2);
                check_eq("t4_req0_ready", {req0_valid, req0_ready}, 2'b10);
                check_eq("t4_rsp_valid", rsp_valid, 1);
                check_eq("t4_rsp_first", rsp_result, 32'd3);
                check_eq("t4_alu_hold", alu_dataA, 32'd10);
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        wait_drain();
        check_eq("t4_responses", rsp_count - r_before, 3);
        check_eq("t4_last", last_rsp_result, 32'd99);

        // Random traffic with random response backpressure
        a_before = acc_total;
        r_before = rsp_count;
        rr_rand = 1'b1;
        fork
            repeat (30) begin issue_rand(0); gap(); end
            repeat (30) begin issue_rand(1); gap(); end
        join
        rr_rand = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_drain();
        check_eq("t5_accepts", acc_total - a_before, 60);
        check_eq("t5_responses", rsp_count - r_before, 60);

        // Reset with both stages full drops everything
        rsp_ready = 1'b0;
        issue(0, 32'd3, 32'd4, 4'h0, c_ALUOP_ADD);
        issue(1, 32'h55, 32'h22, 4'h0, c_ALUOP_SUB);
        @(negedge clk);
        check_eq("t6_full_rsp", {rsp_valid, rsp_result}, {1'b1, 32'd7});
        check_eq("t6_full_is", alu_dataA, 32'h55);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk);
        check_eq("t6_ready_in_reset", req0_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        @(negedge clk);
        check_eq("t6_rsp_valid", rsp_valid, 0);
        check_eq("t6_alu_data", {alu_dataA, alu_dataB}, 0);
        check_eq("t6_alu_ctl", {alu_func, alu_aluOp}, 0);
        check_eq("t6_rsp_result", rsp_result, 0);
        @(posedge clk);
        #1;
        r_before = rsp_count;
        rsp_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t6_no_response", rsp_count - r_before, 0);
        @(posedge clk);
        #1;

`ifdef ALU_ARB_PERF_EN
        check_eq("perf_reset0", perf_grant0, 0);
        check_eq("perf_reset1", perf_grant1, 0);
        fork
            repeat (10) begin issue_rand(0); gap(); end
            repeat (6) begin issue_rand(1); gap(); end
        join
        wait_drain();
        check_eq("perf_grant0", perf_grant0, 10);
        check_eq("perf_grant1", perf_grant1, 6);
        dut.r_perf_grant0 = 32'hFFFF_FFFF;
        issue(0, 32'd1, 32'd1, 4'h0, c_ALUOP_ADD);
        check_eq("perf_wrap", perf_grant0, 0);
        wait_drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_share_arbiter
`default_nettype wire
